// File: rtl/gray_counter.sv
// Up/down binary counter with registered Gray output, wrap or one-shot stop, and sync load.
// Latency: one cycle from any input to outputs; there is no backpressure, and en only gates stepping.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             oneshot,
    output logic [WIDTH-1:0] bin_q,
    output logic [WIDTH-1:0] gray_q,
    output logic             tc,
    output logic             done
);

    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    logic             tc_q;
    logic             at_term;
    logic [WIDTH-1:0] step_d;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Terminal is all-ones going up and zero going down; stepping past it is the wrap.
    always_comb begin
        at_term = up_dn ? (&bin_q) : ~(|bin_q);
        step_d  = up_dn ? (bin_q + ONE) : (bin_q - ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COUNT;
            bin_q   <= '0;
            gray_q  <= '0;
            tc_q    <= 1'b0;
        end else if (load) begin
            state_q <= ST_COUNT;
            bin_q   <= load_bin;
            gray_q  <= to_gray(load_bin);
            tc_q    <= 1'b0;
        end else if (state_q == ST_COUNT && en) begin
            if (at_term && oneshot) begin
                // Stop on the terminal value; tc marks the single entry into DONE.
                state_q <= ST_DONE;
                tc_q    <= 1'b1;
            end else begin
                bin_q  <= step_d;
                gray_q <= to_gray(step_d);
                tc_q   <= at_term;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign tc   = tc_q;
    assign done = (state_q == ST_DONE);

endmodule
